spi_master_param: RTL and testbench
===================================

# spi_master_param

Parametrised SPI master, the next generation of `spi_topblock`'s fixed-width engine. It adds configurable word width, clock divider, slave-select count, runtime CPOL/CPHA mode and bit order. It sits between a host-side start/data handshake and the SPI pins, performs one full-duplex word transfer per accepted start, and returns the received word with a one-cycle valid strobe.

## Interface
- `DATA_WIDTH`, default 8: bits per transfer, minimum 2.
- `NUM_SS`, default 4: number of slave-select lines, minimum 1.
- `CLK_DIV`, default 2: `clk` cycles per SCLK half-period, minimum 1.
- `SS_W`, default `max(1, $clog2(NUM_SS))`: width of `ss_sel`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request a transfer; accepted only in IDLE.
- `ss_sel`  in  SS_W  slave index; latched on accept.
- `cpol`  in  1  SCLK idle level; latched on accept.
- `cpha`  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accept.
- `lsb_first`  in  1  bit order; latched on accept.
- `tx_data`  in  DATA_WIDTH  word to send; latched on accept.
- `rx_data`  out  DATA_WIDTH  last received word; held until the next `rx_valid`.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  high from the cycle after accept until the `rx_valid` cycle (exclusive).
- `sclk`  out  1  SPI clock.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in.
- `ss_n`  out  NUM_SS  active-low selects; at most one low.

## Operation
- Reset (`reset` = 0 at a rising edge) forces the following next cycle:
  - state IDLE;
  - `sclk` = 0, `mosi` = 0, `ss_n` = all 1;
  - `busy` = 0, `rx_valid` = 0, `rx_data` = 0.
- Reset applies in any state. A transfer aborted by reset produces no `rx_valid`.
- FSM states: IDLE, SETUP, XFER, HOLD.
- **IDLE**
  - `sclk` = latched `cpol` (0 after reset).
  - `start` = 1 with `ss_sel` < `NUM_SS`: latch all inputs and go to SETUP.
  - `start` with `ss_sel` >= `NUM_SS` is ignored; the FSM stays in IDLE.
- **SETUP** (CLK_DIV cycles)
  - `ss_n[ss_sel]` = 0.
  - `mosi` = first bit: MSB if `lsb_first` = 0, else LSB.
  - `sclk` = cpol.
- **XFER** (2 × DATA_WIDTH half-periods of CLK_DIV cycles)
  - `sclk` toggles at the start of each half-period. Edges alternate leading, trailing.
  - CPHA = 0:
    - sample `miso` on each leading edge;
    - shift `mosi` to the next bit on each trailing edge except the last.
  - CPHA = 1:
    - shift `mosi` on each leading edge; the first leading edge presents bit 0 of the sequence, overwriting the SETUP value;
    - sample on each trailing edge.
  - "Sample" means `miso` is captured in the same `clk` edge that updates `sclk` to the sampling level.
  - Received bits assemble in the same order as transmitted, so a loopback returns `tx_data` unchanged.
- **HOLD** (CLK_DIV cycles)
  - `sclk` = cpol; `ss_n` stays asserted.
  - Then go to IDLE: `ss_n` all 1, `rx_data` updated, `rx_valid` = 1, `busy` = 0, all in the same cycle.
- Input rules:
  - `start` during SETUP/XFER/HOLD is ignored, with no queueing.
  - Changes on mode/data inputs while busy have no effect.
- Divider and bit counters reset on every accept. No state carries over between transfers.

## Timing
- `start` sampled at edge 0 → `busy` = 1 and `ss_n[sel]` = 0 from cycle 1.
- `rx_valid` pulses at cycle 1 + (2 × DATA_WIDTH + 2) × CLK_DIV after accept.
  - Defaults (W = 8, D = 2): cycle 37.
- Back-to-back transfers:
  - `start` high in the `rx_valid` cycle is accepted (the FSM is in IDLE).
  - Minimum `ss_n` high time between transfers is therefore 1 cycle.
- SCLK frequency = f_clk / (2 × CLK_DIV). CLK_DIV = 1 must work.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Mode 0 loopback.** W = 8, D = 2, `mosi` tied to `miso`, `tx_data` = 0xA5, `ss_sel` = 2.
  - `ss_n` = 4'b1011 for cycles 1–36.
  - 16 `sclk` edges, first one rising.
  - `rx_valid` at cycle 37 with `rx_data` = 0xA5.
- **Mode 3, fixed slave pattern.** Model shifts 0x3C MSB-first, `tx_data` = 0xFF.
  - `sclk` idles high; first edge falling.
  - `rx_data` = 0x3C; model receives 0xFF.
- **LSB-first, mode 1.** `tx_data` = 0x01.
  - `mosi` is 1 during the first bit period and 0 afterwards.
  - Loopback `rx_data` = 0x01.
- **Start while busy / invalid select.**
  - Second `start` at cycle 10 → only one `rx_valid`; `rx_data` is unchanged by the ignored request.
  - `ss_sel` = 5 with NUM_SS = 4 → `busy` stays 0 and `ss_n` stays 4'hF.
- **Reset mid-transfer.** `reset` = 0 at cycle 20.
  - Cycle 21: `ss_n` = 4'hF, `sclk` = 0, `busy` = 0, `rx_data` = 0.
  - No `rx_valid` follows.
  - A new start after release completes normally.
- **Back-to-back, CLK_DIV = 1, W = 16.** Two transfers, 0xBEEF then 0x1234, loopback.
  - `rx_valid` at cycles 35 and 70, returning the words in order.
  - `ss_n` high for exactly 1 cycle between transfers.

Source files
------------

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: one word per accepted start, runtime CPOL/CPHA
// and bit order, CLK_DIV system clocks per SCLK half-period.
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SS     = 4,
  parameter int CLK_DIV    = 2,
  parameter int SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SS_W-1:0]       ss_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SS-1:0]     ss_n
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

  state_e                  state_q;
  logic [DIV_W-1:0]        div_q;
  logic [EDGE_W-1:0]       edge_q;
  logic [DATA_WIDTH-1:0]   tx_sh_q, rx_sh_q, rx_data_q;
  logic                    cpol_q, cpha_q, lsb_q;
  logic                    sclk_q, mosi_q, busy_q, rx_valid_q;
  logic [NUM_SS-1:0]       ss_n_q;

  logic                    sel_ok_d, div_end_d, leading_d, do_shift_d, do_sample_d;
  logic                    nxt_bit_d, cur_bit_d, first_bit_d;
  logic [NUM_SS-1:0]       sel_mask_d;
  logic [EDGE_W-1:0]       edge_idx_d;
  logic [DATA_WIDTH-1:0]   tx_shifted_d, rx_shifted_d;

  always_comb begin
    sel_mask_d = '0;
    for (int i = 0; i < NUM_SS; i++) sel_mask_d[i] = (ss_sel == SS_W'(i));
  end

  assign sel_ok_d    = {1'b0, ss_sel} < (SS_W + 1)'(NUM_SS);
  assign first_bit_d = lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];
  assign div_end_d   = (div_q == DIV_LAST);
  // Index of the SCLK edge fired when the current half-period ends; even = leading.
  assign edge_idx_d  = (state_q == SETUP) ? '0 : edge_q + EDGE_W'(1);
  assign leading_d   = ~edge_idx_d[0];
  assign do_shift_d  = cpha_q ? (leading_d && (edge_idx_d != '0))
                              : (!leading_d && (edge_idx_d != EDGE_LAST));
  assign do_sample_d = cpha_q ? !leading_d : leading_d;

  assign tx_shifted_d = lsb_q ? {1'b0, tx_sh_q[DATA_WIDTH-1:1]} : {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
  assign nxt_bit_d    = lsb_q ? tx_shifted_d[0] : tx_shifted_d[DATA_WIDTH-1];
  assign cur_bit_d    = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1];
  // Received bits land in the same order they were sent, so loopback is identity.
  assign rx_shifted_d = lsb_q ? {miso, rx_sh_q[DATA_WIDTH-1:1]} : {rx_sh_q[DATA_WIDTH-2:0], miso};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      ss_n_q     <= '1;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q <= cpol_q;
          if (start && sel_ok_d) begin
            state_q <= SETUP;
            div_q   <= '0;
            edge_q  <= '0;
            tx_sh_q <= tx_data;
            rx_sh_q <= '0;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            lsb_q   <= lsb_first;
            sclk_q  <= cpol;
            mosi_q  <= first_bit_d;
            ss_n_q  <= ~sel_mask_d;
            busy_q  <= 1'b1;
          end
        end
        SETUP, XFER: begin
          if (!div_end_d) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (state_q == XFER && edge_q == EDGE_LAST) begin
              state_q <= HOLD;
            end else begin
              state_q <= XFER;
              edge_q  <= edge_idx_d;
              sclk_q  <= ~sclk_q;
              if (do_shift_d) begin
                tx_sh_q <= tx_shifted_d;
                mosi_q  <= nxt_bit_d;
              end else if (cpha_q && leading_d) begin
                mosi_q  <= cur_bit_d;
              end
              if (do_sample_d) rx_sh_q <= rx_shifted_d;
            end
          end
        end
        HOLD: begin
          if (!div_end_d) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            state_q    <= IDLE;
            div_q      <= '0;
            ss_n_q     <= '1;
            rx_data_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: default-width instance (3-bit select to reach
// out-of-range indices) plus a 16-bit, CLK_DIV=1 instance for back-to-back traffic.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       reset;
  logic       start0, cpol0, cpha0, lsb0, miso0;
  logic [2:0] sel0;
  logic [7:0] tx0, rxd0;
  logic       rxv0, busy0, sclk0, mosi0;
  logic [3:0] ss_n0;

  logic        start1, cpol1, cpha1, lsb1;
  logic [1:0]  sel1;
  logic [15:0] tx1, rxd1;
  logic        rxv1, busy1, sclk1, mosi1;
  logic [3:0]  ss_n1;

  spi_master_param #(.DATA_WIDTH(8), .NUM_SS(4), .CLK_DIV(2), .SS_W(3)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .ss_sel(sel0), .cpol(cpol0), .cpha(cpha0),
    .lsb_first(lsb0), .tx_data(tx0), .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0),
    .sclk(sclk0), .mosi(mosi0), .miso(miso0), .ss_n(ss_n0));

  spi_master_param #(.DATA_WIDTH(16), .NUM_SS(4), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ss_sel(sel1), .cpol(cpol1), .cpha(cpha1),
    .lsb_first(lsb1), .tx_data(tx1), .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1),
    .sclk(sclk1), .mosi(mosi1), .miso(mosi1), .ss_n(ss_n1));

  // Mode-3 slave: presents 0x3C MSB-first on falling SCLK, captures MOSI on rising.
  logic       loop_en = 1'b1;
  logic       slv_clr = 1'b0;
  logic       slv_bit = 1'b0;
  logic [7:0] slv_word = 8'h3C;
  logic [7:0] slv_rx = 8'h00;
  int         slv_idx = 0;

  assign miso0 = loop_en ? mosi0 : slv_bit;

  always @(posedge sclk0 or negedge sclk0 or posedge slv_clr) begin
    if (slv_clr) begin
      slv_idx <= 0;
      slv_rx  <= 8'h00;
      slv_bit <= 1'b0;
    end else if (!sclk0) begin
      if (slv_idx < 8) slv_bit <= slv_word[7-slv_idx];
      slv_idx <= slv_idx + 1;
    end else if (slv_idx > 0) begin
      slv_rx <= {slv_rx[6:0], mosi0};
    end
  end

  logic       mosi_tr [0:79];
  logic       sclk_tr [0:79];
  logic [3:0] snap_ss;
  logic       snap_sclk, snap_busy;
  logic [7:0] snap_rxd;

  // Runs one dut0 transfer from the current negedge (cycle 0) and records what it sees.
  task automatic run0(input logic [7:0] tx, input logic [2:0] sel, input logic cpol, cpha, lsb,
                      input logic loop, input logic [3:0] exp_ss, input int restart_cyc,
                      input int rst_cyc, input int ncyc, output int vcyc, output int vcnt,
                      output logic [7:0] vdata, output int edges, output int first_val,
                      output int ss_bad, output int busy_bad);
    loop_en = loop; tx0 = tx; sel0 = sel; cpol0 = cpol; cpha0 = cpha; lsb0 = lsb; start0 = 1'b1;
    vcyc = -1; vcnt = 0; vdata = 8'h00; edges = 0; first_val = -1; ss_bad = 0; busy_bad = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      mosi_tr[k] = mosi0;
      sclk_tr[k] = sclk0;
      if (k > 1 && sclk0 !== sclk_tr[k-1]) begin
        edges++;
        if (first_val < 0) first_val = int'(sclk0);
      end
      if (rxv0 === 1'b1) begin
        vcnt++;
        if (vcyc < 0) begin vcyc = k; vdata = rxd0; end
      end
      if (rst_cyc < 0 && k <= 36) begin
        if (ss_n0 !== exp_ss) ss_bad++;
        if (busy0 !== 1'b1) busy_bad++;
      end
      if (k == rst_cyc + 1) begin
        snap_ss = ss_n0; snap_sclk = sclk0; snap_busy = busy0; snap_rxd = rxd0;
        reset = 1'b1;
      end
      if (k == rst_cyc) reset = 1'b0;
      if (k == restart_cyc) begin start0 = 1'b1; tx0 = ~tx; cpol0 = ~cpol; end
    end
  endtask

  int vcyc, vcnt, edges, first_val, ss_bad, busy_bad;
  logic [7:0] vdata;

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ss_n0 !== 4'hF) begin errors++; $display("FAIL reset_ss_n got %h want f", ss_n0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk0); end
    checks++; if (mosi0 !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++; if (rxv0 !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rxv0); end
    checks++; if (rxd0 !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rxd0); end
    checks++; if (ss_n1 !== 4'hF) begin errors++; $display("FAIL reset_ss_n1 got %h want f", ss_n1); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0;
    run0(8'hA5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, -1, -1, 40,
         vcyc, vcnt, vdata, edges, first_val, ss_bad, busy_bad);
    checks++; if (ss_bad != 0) begin errors++; $display("FAIL m0_ss_n bad_cycles %0d want 0", ss_bad); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL m0_busy bad_cycles %0d want 0", busy_bad); end
    checks++; if (edges != 16) begin errors++; $display("FAIL m0_edges got %0d want 16", edges); end
    checks++; if (first_val != 1) begin errors++; $display("FAIL m0_first_edge got %0d want 1", first_val); end
    checks++; if (vcyc != 37) begin errors++; $display("FAIL m0_valid_cycle got %0d want 37", vcyc); end
    checks++; if (vcnt != 1) begin errors++; $display("FAIL m0_valid_count got %0d want 1", vcnt); end
    checks++; if (vdata !== 8'hA5) begin errors++; $display("FAIL m0_rx_data got %h want a5", vdata); end
    checks++; if (rxd0 !== 8'hA5) begin errors++; $display("FAIL m0_rx_hold got %h want a5", rxd0); end
  endtask

  task automatic test_mode3;
    slv_clr = 1'b1; #1; slv_clr = 1'b0;
    run0(8'hFF, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1101, -1, -1, 40,
         vcyc, vcnt, vdata, edges, first_val, ss_bad, busy_bad);
    checks++; if (sclk_tr[1] !== 1'b1) begin errors++; $display("FAIL m3_setup_sclk got %b want 1", sclk_tr[1]); end
    checks++; if (first_val != 0) begin errors++; $display("FAIL m3_first_edge got %0d want 0", first_val); end
    checks++; if (edges != 16) begin errors++; $display("FAIL m3_edges got %0d want 16", edges); end
    checks++; if (sclk_tr[40] !== 1'b1) begin errors++; $display("FAIL m3_idle_sclk got %b want 1", sclk_tr[40]); end
    checks++; if (ss_bad != 0) begin errors++; $display("FAIL m3_ss_n bad_cycles %0d want 0", ss_bad); end
    checks++; if (vdata !== 8'h3C) begin errors++; $display("FAIL m3_rx_data got %h want 3c", vdata); end
    checks++; if (slv_rx !== 8'hFF) begin errors++; $display("FAIL m3_slave_rx got %h want ff", slv_rx); end
  endtask

  task automatic test_lsb_mode1;
    int hi_bad, lo_bad;
    run0(8'h01, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0111, -1, -1, 40,
         vcyc, vcnt, vdata, edges, first_val, ss_bad, busy_bad);
    hi_bad = 0; lo_bad = 0;
    for (int k = 1; k <= 6; k++) if (mosi_tr[k] !== 1'b1) hi_bad++;
    for (int k = 7; k <= 36; k++) if (mosi_tr[k] !== 1'b0) lo_bad++;
    checks++; if (hi_bad != 0) begin errors++; $display("FAIL lsb_mosi_first_bit bad_cycles %0d want 0", hi_bad); end
    checks++; if (lo_bad != 0) begin errors++; $display("FAIL lsb_mosi_rest bad_cycles %0d want 0", lo_bad); end
    checks++; if (vcyc != 37) begin errors++; $display("FAIL lsb_valid_cycle got %0d want 37", vcyc); end
    checks++; if (vdata !== 8'h01) begin errors++; $display("FAIL lsb_rx_data got %h want 01", vdata); end
  endtask

  task automatic test_busy_invalid;
    int bad, vseen;
    logic [2:0] bad_sel [0:1];
    run0(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110, 10, -1, 45,
         vcyc, vcnt, vdata, edges, first_val, ss_bad, busy_bad);
    checks++; if (vcnt != 1) begin errors++; $display("FAIL busy_valid_count got %0d want 1", vcnt); end
    checks++; if (vcyc != 37) begin errors++; $display("FAIL busy_valid_cycle got %0d want 37", vcyc); end
    checks++; if (vdata !== 8'h5A) begin errors++; $display("FAIL busy_rx_data got %h want 5a", vdata); end
    checks++; if (ss_bad != 0) begin errors++; $display("FAIL busy_ss_n bad_cycles %0d want 0", ss_bad); end
    bad_sel[0] = 3'd5; bad_sel[1] = 3'd4;
    for (int s = 0; s < 2; s++) begin
      bad = 0; vseen = 0;
      sel0 = bad_sel[s]; tx0 = 8'h77; start0 = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        start0 = 1'b0;
        if (busy0 !== 1'b0 || ss_n0 !== 4'hF) bad++;
        if (rxv0 !== 1'b0) vseen++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL invalid_sel_%0d bad_cycles %0d want 0", bad_sel[s], bad); end
      checks++; if (vseen != 0) begin errors++; $display("FAIL invalid_sel_valid_%0d got %0d want 0", bad_sel[s], vseen); end
    end
    checks++; if (rxd0 !== 8'h5A) begin errors++; $display("FAIL invalid_rx_hold got %h want 5a", rxd0); end
  endtask

  task automatic test_reset_mid;
    run0(8'hC3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, -1, 20, 60,
         vcyc, vcnt, vdata, edges, first_val, ss_bad, busy_bad);
    checks++; if (snap_ss !== 4'hF) begin errors++; $display("FAIL rst_ss_n got %h want f", snap_ss); end
    checks++; if (snap_sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b want 0", snap_sclk); end
    checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", snap_busy); end
    checks++; if (snap_rxd !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h want 00", snap_rxd); end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL rst_no_valid got %0d want 0", vcnt); end
    run0(8'h96, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, -1, -1, 40,
         vcyc, vcnt, vdata, edges, first_val, ss_bad, busy_bad);
    checks++; if (vcyc != 37) begin errors++; $display("FAIL rst_after_cycle got %0d want 37", vcyc); end
    checks++; if (vdata !== 8'h96) begin errors++; $display("FAIL rst_after_data got %h want 96", vdata); end
  endtask

  task automatic test_back_to_back;
    int n, hi;
    int vc [0:3];
    logic [15:0] vd [0:3];
    n = 0; hi = 0;
    sel1 = 2'd0; cpol1 = 1'b0; cpha1 = 1'b0; lsb1 = 1'b0; tx1 = 16'hBEEF; start1 = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (rxv1 === 1'b1) begin
        if (n < 4) begin vc[n] = k; vd[n] = rxd1; end
        n++;
      end
      if (k >= 2 && k <= 69 && ss_n1 === 4'hF) hi++;
      if (k == 35) begin start1 = 1'b1; tx1 = 16'h1234; end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_valid_count got %0d want 2", n); end
    if (n >= 2) begin
      checks++; if (vc[0] != 35) begin errors++; $display("FAIL b2b_first_cycle got %0d want 35", vc[0]); end
      checks++; if (vd[0] !== 16'hBEEF) begin errors++; $display("FAIL b2b_first_data got %h want beef", vd[0]); end
      checks++; if (vc[1] != 70) begin errors++; $display("FAIL b2b_second_cycle got %0d want 70", vc[1]); end
      checks++; if (vd[1] !== 16'h1234) begin errors++; $display("FAIL b2b_second_data got %h want 1234", vd[1]); end
    end
    checks++; if (hi != 1) begin errors++; $display("FAIL b2b_ss_high got %0d want 1", hi); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start0 = 1'b0; sel0 = 3'd0; cpol0 = 1'b0; cpha0 = 1'b0; lsb0 = 1'b0; tx0 = 8'h00;
    start1 = 1'b0; sel1 = 2'd0; cpol1 = 1'b0; cpha1 = 1'b0; lsb1 = 1'b0; tx1 = 16'h0000;
    test_reset();
    test_mode0();
    test_mode3();
    test_lsb_mode1();
    test_busy_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
